gated_delay_pipe: RTL and testbench



---
 rtl/gdp_pkg.sv | 20 ++
 rtl/gdp_stage_chain.sv | 27 ++
 rtl/gated_delay_pipe.sv | 78 +++++++
 tb/tb_gated_delay_pipe.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/gdp_pkg.sv
// Shared constants and helpers for gated_delay_pipe: combine-mode codes, fill-counter
// width and a saturating increment used by the optional hit counter.
package gdp_pkg;

  localparam int unsigned MODE_OR  = 0;
  localparam int unsigned MODE_XOR = 1;

  // Enough bits to count 0..depth inclusive.
  function automatic int unsigned fill_width(input int unsigned depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

  // Increment val, sticking at the all-ones value of a width-bit counter (width <= 32).
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
    logic [31:0] max_val;
    max_val = (width >= 32) ? 32'hffff_ffff : ((32'd1 << width) - 32'd1);
    return (val >= max_val) ? max_val : val + 32'd1;
  endfunction

endpackage

// File: rtl/gdp_stage_chain.sv
// Channel-vector shift chain of DEPTH flops with asynchronous active-high reset and
// a shift enable; all stages hold when en is low.
module gdp_stage_chain #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) stage_q[k] <= '0;
    end else if (en) begin
      stage_q[0] <= d;
      for (int k = 1; k < DEPTH; k++) stage_q[k] <= stage_q[k-1];
    end
  end

  assign q = stage_q[DEPTH-1];

endmodule

// File: rtl/gated_delay_pipe.sv
// Per-channel combine (OR/XOR), DEPTH-stage stallable delay, inverted-gate qualify,
// fill tracking with out_vld. Optional saturating hit counter under GDP_HIT_COUNT_EN.
module gated_delay_pipe
  import gdp_pkg::*;
#(
  parameter int unsigned CH    = 4,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned MODE  = 0,
  parameter int unsigned CNT_W = 8
) (
  input  logic             gdp_clk,
  input  logic             gdp_rst,
  input  logic [CH-1:0]    in_a,
  input  logic [CH-1:0]    in_b,
  input  logic [CH-1:0]    gate_n,
  input  logic             stall,
  output logic [CH-1:0]    out_q,
  output logic             out_vld
`ifdef GDP_HIT_COUNT_EN
  ,
  output logic [CNT_W-1:0] hit_cnt
`endif
);

  localparam int unsigned FILL_W = fill_width(DEPTH);

  logic [CH-1:0]     comb_c;
  logic [CH-1:0]     tap;
  logic [FILL_W-1:0] fill_q;

  if (MODE > MODE_XOR) begin : g_bad_mode
    $error("gated_delay_pipe: MODE must be 0 (OR) or 1 (XOR)");
  end

  if (MODE == MODE_XOR) begin : g_xor
    assign comb_c = in_a ^ in_b;
  end else begin : g_or
    assign comb_c = in_a | in_b;
  end

  gdp_stage_chain #(
    .WIDTH (CH),
    .DEPTH (DEPTH)
  ) u_chain (
    .clk (gdp_clk),
    .rst (gdp_rst),
    .en  (~stall),
    .d   (comb_c),
    .q   (tap)
  );

  always_ff @(posedge gdp_clk or posedge gdp_rst) begin
    if (gdp_rst) begin
      fill_q <= '0;
    end else if (!stall && (fill_q != FILL_W'(DEPTH))) begin
      fill_q <= fill_q + 1'b1;
    end
  end

  // Gate is deliberately unregistered: zero-cycle gate_n -> out_q path.
  assign out_q   = ~gate_n & tap;
  assign out_vld = (fill_q == FILL_W'(DEPTH));

`ifdef GDP_HIT_COUNT_EN
  logic [CNT_W-1:0] hit_q;

  always_ff @(posedge gdp_clk or posedge gdp_rst) begin
    if (gdp_rst) begin
      hit_q <= '0;
    end else if (!stall && out_vld && (|out_q)) begin
      hit_q <= CNT_W'(sat_inc(32'(hit_q), CNT_W));
    end
  end

  assign hit_cnt = hit_q;
`endif

endmodule

// File: tb/tb_gated_delay_pipe.sv
// Directed bench for gated_delay_pipe: an OR instance (CNT_W=8) and an XOR instance
// (CNT_W=2) share stimulus and are checked against a sample-history model every cycle.
module tb_gated_delay_pipe;

  localparam int unsigned CH    = 4;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned HBUF  = 256;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [CH-1:0] in_a = '0, in_b = '0, gate_n = '0;
  logic          stall = 1'b0;
  logic [CH-1:0] out_q0, out_q1;
  logic          out_vld0, out_vld1;
`ifdef GDP_HIT_COUNT_EN
  logic [7:0]    hit_cnt0;
  logic [1:0]    hit_cnt1;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gated_delay_pipe #(.CH(CH), .DEPTH(DEPTH), .MODE(0), .CNT_W(8)) u_dut_or (
    .gdp_clk (clk),
    .gdp_rst (rst),
    .in_a    (in_a),
    .in_b    (in_b),
    .gate_n  (gate_n),
    .stall   (stall),
    .out_q   (out_q0),
    .out_vld (out_vld0)
`ifdef GDP_HIT_COUNT_EN
    ,
    .hit_cnt (hit_cnt0)
`endif
  );

  gated_delay_pipe #(.CH(CH), .DEPTH(DEPTH), .MODE(1), .CNT_W(2)) u_dut_xor (
    .gdp_clk (clk),
    .gdp_rst (rst),
    .in_a    (in_a),
    .in_b    (in_b),
    .gate_n  (gate_n),
    .stall   (stall),
    .out_q   (out_q1),
    .out_vld (out_vld1)
`ifdef GDP_HIT_COUNT_EN
    ,
    .hit_cnt (hit_cnt1)
`endif
  );

  // Model: history of every combined sample taken on a non-stalled edge. The output is
  // the sample taken DEPTH accepted edges ago, provided DEPTH samples exist since reset.
  logic [CH-1:0] hist_or  [HBUF];
  logic [CH-1:0] hist_xor [HBUF];
  int unsigned   n_acc  = 0;
  int unsigned   n_base = 0;
  int unsigned   hit_or_m  = 0;
  int unsigned   hit_xor_m = 0;

  function automatic bit m_vld();
    return (n_acc - n_base) >= DEPTH;
  endfunction

  function automatic logic [CH-1:0] m_out(input bit use_xor);
    logic [CH-1:0] t;
    if (!m_vld()) return '0;
    t = use_xor ? hist_xor[(n_acc - DEPTH) % HBUF] : hist_or[(n_acc - DEPTH) % HBUF];
    return ~gate_n & t;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      n_base    <= n_acc;
      hit_or_m  <= 0;
      hit_xor_m <= 0;
    end else if (!stall) begin
      if (m_vld() && |m_out(1'b0)) hit_or_m  <= (hit_or_m  >= 255) ? 255 : hit_or_m + 1;
      if (m_vld() && |m_out(1'b1)) hit_xor_m <= (hit_xor_m >= 3)   ? 3   : hit_xor_m + 1;
      hist_or[n_acc % HBUF]  <= in_a | in_b;
      hist_xor[n_acc % HBUF] <= in_a ^ in_b;
      n_acc <= n_acc + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("model_or_q",    32'(out_q0),   32'(m_out(1'b0)));
    check("model_or_vld",  32'(out_vld0), 32'(m_vld()));
    check("model_xor_q",   32'(out_q1),   32'(m_out(1'b1)));
    check("model_xor_vld", 32'(out_vld1), 32'(m_vld()));
`ifdef GDP_HIT_COUNT_EN
    check("model_hit_or",  32'(hit_cnt0), hit_or_m);
    check("model_hit_xor", 32'(hit_cnt1), hit_xor_m);
`endif
  end

  // Apply inputs, then advance past the next rising edge.
  task automatic drive(input logic [CH-1:0] a, input logic [CH-1:0] b,
                       input logic [CH-1:0] g, input logic s);
    in_a = a; in_b = b; gate_n = g; stall = s;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // 1: reset and fill
    rst = 1'b1;
    #12;
    rst = 1'b0;
    check("rst_vld", 32'(out_vld0), 32'd0);
    check("rst_q", 32'(out_q0), 32'd0);
    drive(4'b0000, 4'b0000, 4'b0000, 1'b0);
    check("fill1_vld", 32'(out_vld0), 32'd0);
    drive(4'b0000, 4'b0000, 4'b0000, 1'b0);
    check("fill2_vld", 32'(out_vld0), 32'd1);

    // 2: OR latency
    drive(4'b0001, 4'b0100, 4'b0000, 1'b0);
    check("lat_e1", 32'(out_q0), 32'h0);
    drive(4'b0000, 4'b0000, 4'b0000, 1'b0);
    check("lat_e2_or", 32'(out_q0), 32'h5);
    check("lat_e2_xor", 32'(out_q1), 32'h5);
    drive(4'b0000, 4'b0000, 4'b0000, 1'b0);
    check("lat_e3", 32'(out_q0), 32'h0);

    // 3: zero-latency gate on a held stage value
    drive(4'b1111, 4'b0000, 4'b0000, 1'b0);
    drive(4'b0000, 4'b0000, 4'b0000, 1'b0);
    check("gate_open", 32'(out_q0), 32'hf);
    stall = 1'b1; gate_n = 4'b1010;
    #1;
    check("gate_1010", 32'(out_q0), 32'h5);
    gate_n = 4'b1111;
    #1;
    check("gate_1111", 32'(out_q0), 32'h0);
    drive(4'b0000, 4'b0000, 4'b0000, 1'b1);
    check("gate_held", 32'(out_q0), 32'hf);

    // 4: stall
    drive(4'b0011, 4'b0000, 4'b0000, 1'b0);
    check("stall_e1", 32'(out_q0), 32'h0);
    for (int i = 0; i < 3; i++) begin
      drive(4'b0000, 4'b0000, 4'b0000, 1'b1);
      check("stall_hold", 32'(out_q0), 32'h0);
    end
    drive(4'b0000, 4'b0000, 4'b0000, 1'b0);
    check("stall_release", 32'(out_q0), 32'h3);

    // 5: async reset mid-cycle, then refill with a stall inside
    drive(4'b1111, 4'b0000, 4'b0000, 1'b0);
    drive(4'b1111, 4'b0000, 4'b0000, 1'b0);
    check("full_q", 32'(out_q0), 32'hf);
    #2;
    rst = 1'b1;
    #1;
    check("arst_q", 32'(out_q0), 32'h0);
    check("arst_vld", 32'(out_vld0), 32'd0);
    rst = 1'b0;
    drive(4'b0000, 4'b0000, 4'b0000, 1'b1);
    check("refill_stall_vld", 32'(out_vld0), 32'd0);
    drive(4'b0000, 4'b0000, 4'b0000, 1'b0);
    check("refill1_vld", 32'(out_vld0), 32'd0);
    drive(4'b0000, 4'b0000, 4'b0000, 1'b0);
    check("refill2_vld", 32'(out_vld0), 32'd1);

    // 6: XOR cancellation and saturating hit count
    drive(4'b1111, 4'b1111, 4'b0000, 1'b0);
    drive(4'b1111, 4'b1111, 4'b0000, 1'b0);
    check("xor_cancel", 32'(out_q1), 32'h0);
    check("or_same", 32'(out_q0), 32'hf);
    for (int i = 0; i < 7; i++) drive(4'b1000, 4'b0000, 4'b0000, 1'b0);
    check("xor_1000", 32'(out_q1), 32'h8);
`ifdef GDP_HIT_COUNT_EN
    check("hit_sat", 32'(hit_cnt1), 32'd3);
    drive(4'b1000, 4'b0000, 4'b0000, 1'b0);
    check("hit_stays", 32'(hit_cnt1), 32'd3);
`endif

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
